fifo_sync_core: RTL and testbench
=================================

# fifo_sync_core

Single-clock, parameterised FIFO that merges pointer control and storage into one block: binary write/read pointers with wrap bit, a register-array memory, full/empty and programmable almost-full/almost-empty flags, an occupancy count and sticky overflow/underflow error flags. A `FWFT` parameter selects the read mode: registered standard read, or first-word-fall-through. It is the general-purpose buffer between datapath stages (ALU operand/result queues) and replaces separate pointer logic wrapped around a bare memory.

## Interface
- `DATA_WIDTH`, 8: word width in bits.
- `ADDR_SIZE`, 2: address bits; depth `DEPTH = 2**ADDR_SIZE`.
- `FWFT`, 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.
- `AF_TH`, DEPTH-1: `almost_full` asserts when count >= AF_TH.
- `AE_TH`, 1: `almost_empty` asserts when count <= AE_TH.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: write request.
- `wdata` in DATA_WIDTH: write data.
- `rd_en` in 1: read request (pop).
- `clr_err` in 1: synchronous clear of sticky error flags.
- `rdata` out DATA_WIDTH: read data.
- `rvalid` out 1: standard mode: `rdata` updated this cycle. FWFT mode: equals `!empty`.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: count >= AF_TH.
- `almost_empty` out 1: count <= AE_TH.
- `count` out ADDR_SIZE+1: words stored, 0..DEPTH.
- `overflow` out 1: sticky, a write was rejected.
- `underflow` out 1: sticky, a read was rejected.

## Operation
- Pointers `wptr`, `rptr` are ADDR_SIZE+1 bits. Low ADDR_SIZE bits address memory; the MSB is the wrap bit. `count = wptr - rptr`, computed modulo 2^(ADDR_SIZE+1). `full`: MSBs differ and low bits are equal. `empty`: pointers are equal.
- Accepted write: `wr_acc = wr_en & (!full | rd_acc)`. Accepted read: `rd_acc = rd_en & !empty`.
- On `wr_acc`: `mem[wptr[ADDR_SIZE-1:0]] <= wdata`, then `wptr` increments.
- On `rd_acc`: `rptr` increments.
- Full with simultaneous read and write: both are accepted, and count stays at DEPTH.
- Empty with simultaneous read and write: the write is accepted and the read is rejected. This sets `underflow`. Count becomes 1.
- `wr_en & !wr_acc` sets `overflow`. `rd_en & !rd_acc` sets `underflow`.
- `clr_err` clears both error flags. If a new error occurs in the same cycle as `clr_err`, the set wins.
- Memory contents are not reset.
- Standard mode (FWFT=0): on `rd_acc`, `rdata <= mem[rptr]` is registered, and `rvalid` is 1 in the next cycle. Otherwise `rdata` holds its value and `rvalid` = 0.
- FWFT mode (FWFT=1): `rdata = mem[rptr[ADDR_SIZE-1:0]]` combinationally. It shows the head word whenever `!empty`. `rd_en` pops the head. `rdata` is don't-care when empty.
- Pointers wrap naturally at 2^(ADDR_SIZE+1). No special case is needed at the DEPTH boundary.
- Parameter legality: 0 < AF_TH <= DEPTH and 0 <= AE_TH < DEPTH. Illegal values are flagged by a simulation-only check.

## Timing
- Reset values: `wptr` = `rptr` = 0, `rdata` = 0, `rvalid` = 0, `overflow` = `underflow` = 0. So `empty` = 1, `full` = 0, `count` = 0, `almost_empty` = 1, `almost_full` = (AF_TH == 0).
- Reset asserted mid-operation empties the FIFO immediately, independent of `clk`.
- All flags and `count` are derived from registered pointers. They reflect accepted operations one cycle after the edge.
- Write-to-read latency:
  - Standard mode: a word written at edge N can be popped at edge N+1. Its data appears on `rdata` after that pop edge.
  - FWFT mode: the word is visible on `rdata` after edge N, i.e. `empty` deasserts in cycle N+1.
- Throughput: one write and one read per cycle, sustained.

## Test plan
Parameters unless stated: DATA_WIDTH=8, ADDR_SIZE=2 (DEPTH 4), AF_TH=3, AE_TH=1.
- **Reset/fill/drain, FWFT=0:**
  - After reset: `empty`=1, `count`=0, `rdata`=0x00.
  - Write 0x11, 0x22, 0x33, 0x44: `full`=1, `count`=4, and `almost_full` rises when count reaches 3.
  - Four reads: `rdata` = 0x11, 0x22, 0x33, 0x44, each with `rvalid`=1 one cycle after its `rd_en`. Ends with `empty`=1.
- **Overflow/underflow:**
  - A 5th write while full: rejected, `overflow`=1, contents unchanged.
  - A read while empty: `underflow`=1.
  - Pulse `clr_err`: both flags return to 0.
- **Simultaneous access:**
  - Full, with wr 0x55 and rd in the same cycle: both accepted, `count` stays 4, and 0x55 is read 4th.
  - Empty, with wr 0xAA and rd in the same cycle: `count`=1, `underflow`=1.
- **Wrap-around:** 10 cycles of continuous single write + single read with incrementing data 0x00..0x09. Read data matches in order, `count` stays <= 1, and the pointer MSBs toggle.
- **FWFT=1:** write 0x5A, then 0xA5 on the next cycle. `rdata`=0x5A with `rvalid`=1 in the cycle after the first write. Pop once: `rdata`=0xA5. Pop again: `empty`=1, `rvalid`=0.
- **Async reset mid-stream:** with 3 words stored, drop `rst_n` between clock edges. `empty`=1, `count`=0 and `rdata`=0 immediately, before the next edge.

Source files
------------

// File: rtl/fifo_sync_core_if.sv
// Handshake/status bundle for fifo_sync_core: producer/consumer side is master,
// the FIFO itself is slave.
interface fifo_sync_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 2
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_SIZE:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wdata, rd_en, clr_err,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wdata, rd_en, clr_err,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_core.sv
// Single-clock FIFO: wrap-bit pointers, register-array storage, flags, sticky
// errors. FWFT selects registered read (0) or fall-through head word (1).
module fifo_sync_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 2,
  parameter int FWFT       = 0,
  parameter int AF_TH      = (1 << ADDR_SIZE) - 1,
  parameter int AE_TH      = 1
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_core_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AF_C = AF_TH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AE_C = AE_TH[ADDR_SIZE:0];

  if (AF_TH < 1 || AF_TH > DEPTH) begin : g_bad_af
    $error("fifo_sync_core: AF_TH out of range");
  end
  if (AE_TH < 0 || AE_TH >= DEPTH) begin : g_bad_ae
    $error("fifo_sync_core: AE_TH out of range");
  end

  logic [ADDR_SIZE:0]                  wptr_q, rptr_q, wptr_d, rptr_d, cnt;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    mem_q;
  logic                                ovf_q, unf_q, ovf_d, unf_d;
  logic                                full, empty, wr_acc, rd_acc;

  assign cnt    = wptr_q - rptr_q;
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[ADDR_SIZE] != rptr_q[ADDR_SIZE]) &&
                  (wptr_q[ADDR_SIZE-1:0] == rptr_q[ADDR_SIZE-1:0]);
  assign rd_acc = bus.rd_en & ~empty;
  // A pop in the same cycle frees a slot, so a write into a full FIFO is allowed.
  assign wr_acc = bus.wr_en & (~full | rd_acc);

  always_comb begin
    wptr_d = wptr_q + {{ADDR_SIZE{1'b0}}, wr_acc};
    rptr_d = rptr_q + {{ADDR_SIZE{1'b0}}, rd_acc};
    ovf_d  = (ovf_q & ~bus.clr_err) | (bus.wr_en & ~wr_acc);
    unf_d  = (unf_q & ~bus.clr_err) | (bus.rd_en & ~rd_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[ADDR_SIZE-1:0]] <= bus.wdata;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.rdata  = mem_q[rptr_q[ADDR_SIZE-1:0]];
    assign bus.rvalid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem_q[rptr_q[ADDR_SIZE-1:0]];
      end
    end
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = cnt;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_sync_core.sv
// Bench for fifo_sync_core: standard (u0) and FWFT (u1) instances checked
// against a list-based FIFO model, directed steps then random traffic.
module tb_fifo_sync_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_core_if #(.DATA_WIDTH(8), .ADDR_SIZE(2)) b0 ();
  fifo_sync_core_if #(.DATA_WIDTH(8), .ADDR_SIZE(2)) b1 ();

  fifo_sync_core #(.DATA_WIDTH(8), .ADDR_SIZE(2), .FWFT(0), .AF_TH(3), .AE_TH(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  fifo_sync_core #(.DATA_WIDTH(8), .ADDR_SIZE(2), .FWFT(1), .AF_TH(3), .AE_TH(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int npass = 0, ntot = 0;

  // Model: per-DUT list of words held in a 16-slot ring, head index + length.
  logic [7:0] mbuf [2][16];
  int         mhead [2];
  int         mn [2];
  logic [7:0] erd [2];
  logic       erv [2];
  logic       eovf [2], eunf [2];

  logic       we [2], re [2], clr [2];
  logic [7:0] wd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mhead[d] = 0; mn[d] = 0; erd[d] = 8'h00; erv[d] = 1'b0;
      eovf[d] = 1'b0; eunf[d] = 1'b0;
      we[d] = 1'b0; re[d] = 1'b0; clr[d] = 1'b0; wd[d] = 8'h00;
    end
  endtask

  task automatic check();
    chk("s.count",  32'(b0.count),        32'(mn[0]));
    chk("s.full",   32'(b0.full),         32'(mn[0] == 4));
    chk("s.empty",  32'(b0.empty),        32'(mn[0] == 0));
    chk("s.afull",  32'(b0.almost_full),  32'(mn[0] >= 3));
    chk("s.aempty", 32'(b0.almost_empty), 32'(mn[0] <= 1));
    chk("s.ovf",    32'(b0.overflow),     32'(eovf[0]));
    chk("s.unf",    32'(b0.underflow),    32'(eunf[0]));
    chk("s.rvalid", 32'(b0.rvalid),       32'(erv[0]));
    chk("s.rdata",  32'(b0.rdata),        32'(erd[0]));
    chk("f.count",  32'(b1.count),        32'(mn[1]));
    chk("f.full",   32'(b1.full),         32'(mn[1] == 4));
    chk("f.empty",  32'(b1.empty),        32'(mn[1] == 0));
    chk("f.ovf",    32'(b1.overflow),     32'(eovf[1]));
    chk("f.unf",    32'(b1.underflow),    32'(eunf[1]));
    chk("f.rvalid", 32'(b1.rvalid),       32'(mn[1] != 0));
    if (mn[1] != 0) chk("f.rdata", 32'(b1.rdata), 32'(mbuf[1][mhead[1]]));
  endtask

  task automatic tick();
    b0.wr_en = we[0]; b0.wdata = wd[0]; b0.rd_en = re[0]; b0.clr_err = clr[0];
    b1.wr_en = we[1]; b1.wdata = wd[1]; b1.rd_en = re[1]; b1.clr_err = clr[1];
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      logic racc, wacc;
      racc = re[d] && (mn[d] != 0);
      wacc = we[d] && ((mn[d] != 4) || racc);
      erv[d] = 1'b0;
      if (racc) begin
        erd[d] = mbuf[d][mhead[d]]; erv[d] = 1'b1;
        mhead[d] = (mhead[d] + 1) % 16; mn[d]--;
      end
      if (wacc) begin
        mbuf[d][(mhead[d] + mn[d]) % 16] = wd[d]; mn[d]++;
      end
      eovf[d] = (eovf[d] && !clr[d]) || (we[d] && !wacc);
      eunf[d] = (eunf[d] && !clr[d]) || (re[d] && !racc);
    end
    #1 check();
  endtask

  task automatic op0(input logic w, input logic [7:0] data, input logic r, input logic c);
    we[0] = w; wd[0] = data; re[0] = r; clr[0] = c;
    we[1] = 1'b0; wd[1] = 8'h00; re[1] = 1'b0; clr[1] = 1'b0;
    tick();
  endtask

  task automatic op1(input logic w, input logic [7:0] data, input logic r, input logic c);
    we[1] = w; wd[1] = data; re[1] = r; clr[1] = c;
    we[0] = 1'b0; wd[0] = 8'h00; re[0] = 1'b0; clr[0] = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    b0.wr_en = 1'b0; b0.wdata = '0; b0.rd_en = 1'b0; b0.clr_err = 1'b0;
    b1.wr_en = 1'b0; b1.wdata = '0; b1.rd_en = 1'b0; b1.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check();

    // fill, overflow, drain, underflow, clear
    op0(1, 8'h11, 0, 0); op0(1, 8'h22, 0, 0); op0(1, 8'h33, 0, 0); op0(1, 8'h44, 0, 0);
    op0(1, 8'h99, 0, 0);
    repeat (4) op0(0, 8'h00, 1, 0);
    op0(0, 8'h00, 1, 0);
    op0(0, 8'h00, 0, 1);

    // simultaneous access when full, then when empty
    for (int i = 1; i <= 4; i++) op0(1, 8'(i), 0, 0);
    op0(1, 8'h55, 1, 0);
    repeat (4) op0(0, 8'h00, 1, 0);
    op0(1, 8'hAA, 1, 0);
    op0(0, 8'h00, 1, 0);
    op0(0, 8'h00, 0, 1);

    // streaming wrap-around
    op0(1, 8'h00, 0, 0);
    for (int i = 1; i <= 9; i++) op0(1, 8'(i), 1, 0);
    op0(0, 8'h00, 1, 0);

    // fall-through mode
    op1(1, 8'h5A, 0, 0);
    op1(1, 8'hA5, 0, 0);
    op1(0, 8'h00, 1, 0);
    op1(0, 8'h00, 1, 0);

    // random traffic on both
    for (int n = 0; n < 300; n++) begin
      for (int d = 0; d < 2; d++) begin
        we[d]  = ($urandom_range(0, 99) < 55);
        re[d]  = ($urandom_range(0, 99) < 50);
        clr[d] = ($urandom_range(0, 15) == 0);
        wd[d]  = 8'($urandom);
      end
      tick();
    end

    // async reset with three words held and a non-zero rdata
    for (int i = 0; i < 8 && mn[0] != 0; i++) op0(0, 8'h00, 1, 0);
    op0(0, 8'h00, 0, 1);
    op0(1, 8'hC1, 0, 0); op0(1, 8'hC2, 0, 0); op0(1, 8'hC3, 1, 0); op0(1, 8'hC4, 0, 0);
    chk("s.pre_rst_rdata", 32'(b0.rdata), 32'h0000_00C1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check();
    #10 rst_n = 1'b1;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
